brightness_ramp: RTL
====================

BRIGHTNESS_RAMP -- requirements
Module: brightness_ramp

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, meaning the PWM period in clk cycles; it sizes pwm_value.
REQ-002 SHALL have parameter STEP_CYCLES, default 12000, meaning the clk cycles per level step (1 ms at 12 MHz); legal range >= 1.
REQ-003 SHALL have parameter STEP_SIZE, default 1, meaning the level increment or decrement per step; legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port target_level, input, 8 bits: requested brightness level, 0..255.
REQ-007 SHALL have port target_valid, input, 1 bit: target_level is valid this cycle.
REQ-008 SHALL have port target_ready, output, 1 bit: block accepts a new target this cycle.
REQ-009 SHALL have port level, output, 8 bits: current ramped level.
REQ-010 SHALL have port pwm_value, output, $clog2(PWM_INTERVAL) bits: duty value that feeds the pwm stage directly.
REQ-011 SHALL have port busy, output, 1 bit: high while a ramp is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking completion of a request.

Function
REQ-013 SHALL implement the FSM states IDLE, RAMP and DONE.
REQ-014 SHALL drive target_ready = 1 only in IDLE; a handshake occurs when target_valid && target_ready at a rising edge.
REQ-015 On a handshake in cycle N, SHALL latch target_level into an internal target register and clear the step timer.
REQ-016 On that handshake, SHALL go to RAMP at N+1 if the target differs from level, otherwise to DONE at N+1.
REQ-017 In RAMP, SHALL count cycles; level SHALL take its k-th stepped value in cycle N + k*STEP_CYCLES.
REQ-018 Each step SHALL move level toward the target by STEP_SIZE and clamp at the target, with no overshoot and no 8-bit wrap-around (e.g. 250 + 10 toward 255 gives 255).
REQ-019 In the cycle after level equals the target, the FSM SHALL be in DONE with done = 1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL drive busy = 1 in RAMP and DONE, and busy = 0 in IDLE.
REQ-021 SHALL make pwm_value a registered function of level with 1-cycle latency.
REQ-022 SHALL compute pwm_value with a full-width product before the shift, so there is no intermediate overflow; result max 1195 at default PWM_INTERVAL.
REQ-023 Without gamma, pwm_value SHALL be (level * PWM_INTERVAL) >> 8 (level 128 -> 600).
REQ-024 SHALL ignore target_valid outside IDLE; a request is not queued and the current ramp is not retargeted.

Reset
REQ-025 While reset = 1 at a clock edge, SHALL set the FSM to IDLE, level = 0, internal target = 0, timer = 0, pwm_value = 0, busy = 0, done = 0.
REQ-026 SHALL drive target_ready = 1 in the first cycle after reset deasserts.
REQ-027 Reset mid-ramp SHALL abort the ramp with no done pulse; target_valid during reset SHALL be ignored.

Configuration
REQ-028 With macro BRIGHTNESS_RAMP_GAMMA_EN defined, pwm_value SHALL be (level * level * PWM_INTERVAL) >> 16, a square-law gamma.
REQ-029 With BRIGHTNESS_RAMP_GAMMA_EN defined, level 128 -> 300 and level 255 -> 1190 at default PWM_INTERVAL.
REQ-030 Without BRIGHTNESS_RAMP_GAMMA_EN, the linear mapping of REQ-023 applies and no multiplier for level squared is synthesised.
REQ-031 Latency, FSM and handshake SHALL be identical with and without BRIGHTNESS_RAMP_GAMMA_EN.

Verification (STEP_CYCLES = 4, STEP_SIZE = 1 unless noted; handshake in cycle N)
REQ-032 Reset -> level = 0, pwm_value = 0, target_ready = 1, busy = 0, done = 0.
REQ-033 Up-ramp 0 -> 3 -> level = 1, 2, 3 at N+4, N+8, N+12; done pulse at N+13; target_ready = 1 at N+14; pwm_value (linear) = 14 at N+13.
REQ-034 Target equal to level (0 -> 0) -> done at N+1 only; level unchanged; busy high for one cycle.
REQ-035 STEP_SIZE = 100, ramp 0 -> 255 then back to 0 -> up levels 100, 200, 255; down levels 155, 55, 0; no wrap-around.
REQ-036 target_valid held high with target 9 mid-ramp -> ignored; ramp finishes at its original target; 9 is accepted only once IDLE is re-entered.
REQ-037 reset asserted at N+6 of a 0 -> 3 ramp -> level = 0 and pwm_value = 0 next cycle; no done pulse; target_ready = 1 after deassert.
REQ-038 Gamma build, level settled at 128 and then 255 -> pwm_value = 300 and 1190; linear build gives 600 and 1195.

Source files
------------

// File: rtl/brightness_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : brightness_ramp
//  Description : Ramps an 8-bit brightness level toward a requested target in
//                STEP_SIZE increments, one step every STEP_CYCLES clocks, and
//                maps the level to a PWM duty value with one cycle of latency.
//                Optional macro BRIGHTNESS_RAMP_GAMMA_EN selects a square-law
//                gamma mapping instead of the linear one.
//  Ports       : clk          - single clock, rising edge
//                reset        - synchronous active-high reset
//                target_level - requested level 0..255
//                target_valid - target_level valid this cycle
//                target_ready - new target accepted this cycle (IDLE only)
//                level        - current ramped level
//                pwm_value    - duty value for the PWM stage
//                busy         - ramp in progress (RAMP or DONE)
//                done         - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module brightness_ramp #(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_CYCLES  = 12000,
    parameter int STEP_SIZE    = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [7:0]                        target_level,
    input  logic                              target_valid,
    output logic                              target_ready,
    output logic [7:0]                        level,
    output logic [$clog2(PWM_INTERVAL)-1:0]   pwm_value,
    output logic                              busy,
    output logic                              done
);

    localparam int PWM_W   = $clog2(PWM_INTERVAL);
    localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int PROD_W  = 16 + $clog2(PWM_INTERVAL + 1);

    // The handshake cycle counts as the first cycle of the first step
    // interval, so with the timer cleared on accept the step fires when the
    // free-running phase counter reaches STEP_CYCLES-2. A one-cycle step
    // interval therefore steps on every edge, including the accept edge.
    localparam logic [TIMER_W-1:0] c_step_at    = TIMER_W'((STEP_CYCLES >= 2) ? (STEP_CYCLES - 2) : 0);
    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(STEP_CYCLES - 1);
    localparam bit                 c_every_cycle = (STEP_CYCLES == 1);
    localparam logic [7:0]         c_step       = 8'(STEP_SIZE);
    localparam logic [PROD_W-1:0]  c_interval   = PROD_W'(PWM_INTERVAL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_level;
    logic [7:0]         r_target;
    logic [TIMER_W-1:0] r_timer;
    logic [PWM_W-1:0]   r_pwm;
    logic               w_accept;
    logic               w_step;
    logic [PROD_W-1:0]  w_product;
    logic [PWM_W-1:0]   w_pwm_next;

    // One step toward tgt, clamped so the level never passes the target.
    // The gap is checked before adding/subtracting, so no 8-bit wrap occurs.
    function automatic logic [7:0] f_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] gap;
        gap = 8'd0;
        if (tgt > cur) begin
            gap    = tgt - cur;
            f_step = (gap <= c_step) ? tgt : (cur + c_step);
        end else if (tgt < cur) begin
            gap    = cur - tgt;
            f_step = (gap <= c_step) ? tgt : (cur - c_step);
        end else begin
            f_step = cur;
        end
    endfunction

    assign w_accept = (r_state == IDLE) && target_valid;
    assign w_step   = c_every_cycle ? 1'b1 : (r_timer == c_step_at);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (target_valid) begin
                    w_state_next = (target_level != r_level) ? RAMP : DONE;
                end
            end
            RAMP: begin
                // Compares the registered level, so DONE lands the cycle
                // after the level reaches the target.
                if (r_level == r_target) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Target, step timer and level
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target <= 8'd0;
            r_timer  <= '0;
            r_level  <= 8'd0;
        end else if (w_accept) begin
            r_target <= target_level;
            r_timer  <= '0;
            if (c_every_cycle) begin
                r_level <= f_step(r_level, target_level);
            end
        end else if ((r_state == RAMP) && (r_level != r_target)) begin
            r_timer <= (r_timer == c_timer_last) ? '0 : (r_timer + 1'b1);
            if (w_step) begin
                r_level <= f_step(r_level, r_target);
            end
        end
    end

    // ------------------------------------------------------------------
    // Level to duty mapping; full-width product before the shift
    // ------------------------------------------------------------------
`ifdef BRIGHTNESS_RAMP_GAMMA_EN
    always_comb begin
        w_product  = PROD_W'(r_level) * PROD_W'(r_level) * c_interval;
        w_pwm_next = PWM_W'(w_product >> 16);
    end
`else
    always_comb begin
        w_product  = PROD_W'(r_level) * c_interval;
        w_pwm_next = PWM_W'(w_product >> 8);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_pwm_next;
        end
    end

    assign target_ready = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign level        = r_level;
    assign pwm_value    = r_pwm;

endmodule
`default_nettype wire
